regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
- REQ-001: Parameter WIDTH, default 32, data width of each register and of every data port.
- REQ-002: Parameter ADDR_W, default 5, register address width; register count is 2**ADDR_W (32).
- REQ-003: clk  input  1  single clock; all state updates occur on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: RegWrite  input  1  write enable for the current cycle.
- REQ-006: WriteRegister  input  ADDR_W  destination register address.
- REQ-007: WriteData  input  WIDTH  value to write.
- REQ-008: ReadRegister1  input  ADDR_W  read port 1 address.
- REQ-009: ReadRegister2  input  ADDR_W  read port 2 address.
- REQ-010: ReadData1  output  WIDTH  contents of the register at ReadRegister1.
- REQ-011: ReadData2  output  WIDTH  contents of the register at ReadRegister2.

Function
- REQ-012: WriteRegister SHALL be decoded one-hot into 32 per-register enables, each gated by RegWrite.
- REQ-013: On a rising clk edge with RegWrite=1, the register at WriteRegister SHALL load WriteData; all other registers SHALL hold.
- REQ-014: With RegWrite=0, no register SHALL change, regardless of WriteRegister and WriteData.
- REQ-015: Register 0 SHALL always read 0; writes to address 0 SHALL be discarded.
- REQ-016: Reads SHALL be combinational, with zero latency from a ReadRegisterN change to ReadDataN.
- REQ-017: Without bypass, a written value SHALL be visible on a read port in the cycle after the write edge.
- REQ-018: Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
- REQ-019: Write latency SHALL be one edge; back-to-back writes to the same address SHALL leave the last value written.
- REQ-020: X or Z on WriteRegister while RegWrite=0 SHALL NOT corrupt any register.

Reset
- REQ-021: Asserting reset SHALL clear all 32 registers to 0 immediately, without waiting for clk.
- REQ-022: While reset is high, ReadData1 and ReadData2 SHALL read 0 for every address.
- REQ-023: Reset asserted on the same edge as a write SHALL win; the write SHALL be lost.
- REQ-024: The first write SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
- REQ-025: Macro REGFILE_BYPASS_EN, when defined, SHALL enable write-to-read forwarding.
- REQ-026: With forwarding enabled: if RegWrite=1, WriteRegister != 0 and ReadRegisterN == WriteRegister, then ReadDataN SHALL equal WriteData in the same cycle.
- REQ-027: With REGFILE_BYPASS_EN undefined, ReadDataN SHALL show the old register contents until after the write edge.
- REQ-028: Forwarding SHALL never apply to address 0 and SHALL be suppressed while reset is high.

Structure
- REQ-029: A shared package SHALL hold REG_WIDTH=32, REG_ADDR_W=5, REG_COUNT=32, ZERO_REG=0 and a register-array typedef.
- REQ-030: The write decode SHALL be a sub-module, decoder1to32 (inputs: enable, 5-bit address; output: 32-bit one-hot), instantiated once.
- REQ-031: The read selection SHALL use the existing 32-input, 32-bit mux module, one instance per read port.

Verification
- REQ-032: Reset, then read all 32 addresses on both ports -> every ReadData = 0.
- REQ-033: Write 0xDEADBEEF to reg 5 with RegWrite=1; next cycle read reg 5 -> 0xDEADBEEF; regs 4 and 6 -> 0.
- REQ-034: Write 0x12345678 to reg 0, then read reg 0 -> 0.
- REQ-035: RegWrite=0, WriteRegister=7, WriteData=0xFFFFFFFF, one edge -> reg 7 still 0.
- REQ-036: Write 0xA5A5A5A5 to reg 31, then assert reset mid-cycle -> ReadData goes to 0 before the next edge.
- REQ-037: Write 0x00000042 to reg 3 with ReadRegister1=3 in the same cycle -> 0x42 before the edge with REGFILE_BYPASS_EN defined, the old value without it.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
//   REG_WIDTH   - data width of every register (32)
//   REG_ADDR_W  - register address width (5)
//   REG_COUNT   - number of registers (2**REG_ADDR_W = 32)
//   ZERO_REG    - address of the hardwired-zero register
//   reg_array_t - unpacked array holding one value per register
package regfile_pkg;
    localparam int REG_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 2 ** REG_ADDR_W;
    localparam int ZERO_REG   = 0;

    typedef logic [REG_WIDTH-1:0] reg_array_t [REG_COUNT];
endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one write port and two read ports.
// Ports (signals):
//   RegWrite       - write enable for the current cycle
//   WriteRegister  - destination register address
//   WriteData      - value to write
//   ReadRegister1  - read port 1 address
//   ReadRegister2  - read port 2 address
//   ReadData1      - contents of register ReadRegister1
//   ReadData2      - contents of register ReadRegister2
// Modports: master drives addresses/data, slave (the register file) drives read data.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
) ();
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_decoder1to32.sv
// decoder1to32: write-address decoder.
// Ports:
//   enable  - gates every output line (RegWrite)
//   address - register address to decode
//   onehot  - one line per register, at most one high
// The AND with enable is written so that an unknown address with enable low
// still yields all-zero outputs.
module decoder1to32
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 enable,
    input  logic [ADDR_W-1:0]    address,
    output logic [2**ADDR_W-1:0] onehot
);
    generate
        for (genvar gi = 0; gi < 2 ** ADDR_W; gi++) begin : g_line
            assign onehot[gi] = enable && (address == ADDR_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/regfile_mux.sv
// mux32to1: 32-input read-selection multiplexer, one instance per read port.
// Ports:
//   din  - all register values, packed, entry i at din[i]
//   sel  - read address
//   dout - selected value
module mux32to1
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int SEL_W = REG_ADDR_W
) (
    input  logic [2**SEL_W-1:0][WIDTH-1:0] din,
    input  logic [SEL_W-1:0]               sel,
    output logic [WIDTH-1:0]               dout
);
    assign dout = din[sel];
endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit register file, one write port, two combinational read
// ports, register 0 hardwired to zero.
// Ports:
//   clk   - clock, state updates on rising edge
//   reset - asynchronous active-high reset, clears every register
//   bus   - regfile_if.slave (write enable/address/data, two read ports)
// Configuration macro: REGFILE_BYPASS_EN -- when defined, a write in progress
// is forwarded to any read port addressing the same non-zero register.
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);
    localparam int COUNT = 2 ** ADDR_W;

    logic [COUNT-1:0]            write_en;
    logic [COUNT-1:0][WIDTH-1:0] mux_in;
    logic [WIDTH-1:0]            mux_out1;
    logic [WIDTH-1:0]            mux_out2;
    logic                        unused_write_en0;

    decoder1to32 #(.ADDR_W(ADDR_W)) u_decoder (
        .enable  (bus.RegWrite),
        .address (bus.WriteRegister),
        .onehot  (write_en)
    );

    // Register 0 has no storage, so its decode line goes nowhere.
    assign unused_write_en0 = write_en[0];
    assign mux_in[0]        = '0;

    generate
        for (genvar gi = 1; gi < COUNT; gi++) begin : g_reg
            logic [WIDTH-1:0] value_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (write_en[gi]) begin
                    value_reg <= bus.WriteData;
                end
            end

            assign mux_in[gi] = value_reg;
        end
    endgenerate

    mux32to1 #(.WIDTH(WIDTH), .SEL_W(ADDR_W)) u_mux1 (
        .din  (mux_in),
        .sel  (bus.ReadRegister1),
        .dout (mux_out1)
    );

    mux32to1 #(.WIDTH(WIDTH), .SEL_W(ADDR_W)) u_mux2 (
        .din  (mux_out_sel_din()),
        .sel  (bus.ReadRegister2),
        .dout (mux_out2)
    );

    function automatic logic [COUNT-1:0][WIDTH-1:0] mux_out_sel_din();
        return mux_in;
    endfunction

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; never for register 0 and not during reset
    // (reset already holds every stored value at zero).
    logic write_live;
    logic fwd1;
    logic fwd2;

    assign write_live = !reset && bus.RegWrite
                        && (bus.WriteRegister != ADDR_W'(ZERO_REG));
    assign fwd1 = write_live && (bus.ReadRegister1 == bus.WriteRegister);
    assign fwd2 = write_live && (bus.ReadRegister2 == bus.WriteRegister);

    assign bus.ReadData1 = fwd1 ? bus.WriteData : mux_out1;
    assign bus.ReadData2 = fwd2 ? bus.WriteData : mux_out2;
`else
    assign bus.ReadData1 = mux_out1;
    assign bus.ReadData2 = mux_out2;
`endif
endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: expected read values are pushed to a
// scoreboard queue when the read addresses are driven and popped/compared
// once the combinational outputs have settled.
module tb_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_if #(.WIDTH(REG_WIDTH), .ADDR_W(REG_ADDR_W)) bus ();

    regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t        sb[$];
    reg_array_t model;
    int         compared   = 0;
    int         mismatched = 0;

    task automatic check_pop(input logic [31:0] obs);
        sb_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic read_check(input string tag,
                              input logic [4:0] a1, input logic [31:0] e1,
                              input logic [4:0] a2, input logic [31:0] e2);
        bus.ReadRegister1 = a1;
        bus.ReadRegister2 = a2;
        sb.push_back('{tag: {tag, "_p1"}, exp: e1});
        sb.push_back('{tag: {tag, "_p2"}, exp: e2});
        #1;
        check_pop(bus.ReadData1);
        check_pop(bus.ReadData2);
        $display("read %s: r%0d=%h r%0d=%h", tag, a1, bus.ReadData1, a2, bus.ReadData2);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = a;
        bus.WriteData     = d;
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        if (a != 5'd0 && !reset) model[a] = d;
        $display("write r%0d <= %h", a, d);
    endtask

    logic [31:0] exp_same;

    initial begin
        for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
        reset             = 1'b1;
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;

        // Reads while reset is high are zero everywhere.
        repeat (2) @(posedge clk);
        for (int i = 0; i < REG_COUNT; i++)
            read_check("in_reset", 5'(i), 32'h0, 5'(31 - i), 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < REG_COUNT; i++)
            read_check("after_reset", 5'(i), 32'h0, 5'(31 - i), 32'h0);

        // Basic write/read and neighbour isolation.
        do_write(5'd5, 32'hDEADBEEF);
        read_check("r5_written", 5'd5, 32'hDEADBEEF, 5'd4, 32'h0);
        read_check("r6_untouched", 5'd6, 32'h0, 5'd5, 32'hDEADBEEF);
        read_check("same_addr", 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);

        // Register 0 discards writes.
        do_write(5'd0, 32'h12345678);
        read_check("r0_discard", 5'd0, 32'h0, 5'd0, 32'h0);

        // RegWrite low blocks the write, also with an unknown address.
        @(negedge clk);
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 5'd7;
        bus.WriteData     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        read_check("r7_no_we", 5'd7, 32'h0, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        bus.WriteRegister = 'x;
        @(posedge clk);
        #1;
        bus.WriteRegister = '0;
        read_check("x_addr_no_we", 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);

        // Back-to-back writes to the same address keep the last one.
        do_write(5'd9, 32'h0000AAAA);
        do_write(5'd9, 32'h0000BBBB);
        read_check("b2b_last", 5'd9, 32'h0000BBBB, 5'd5, 32'hDEADBEEF);

        // Random writes, then sweep every register on both ports.
        for (int i = 0; i < 24; i++)
            do_write(5'($urandom_range(0, 31)), $urandom);
        for (int i = 0; i < REG_COUNT; i++)
            read_check("sweep", 5'(i), model[i], 5'(31 - i), model[31 - i]);

        // Same-cycle read of a write in progress.
        do_write(5'd3, 32'h00000011);
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd3;
        bus.WriteData     = 32'h00000042;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h00000042;
`else
        exp_same = 32'h00000011;
`endif
        read_check("write_same_cycle", 5'd3, exp_same, 5'd3, exp_same);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        model[3] = 32'h00000042;
        read_check("write_after_edge", 5'd3, 32'h00000042, 5'd0, 32'h0);

        // A write to register 0 is never forwarded.
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd0;
        bus.WriteData     = 32'hFFFFFFFF;
        read_check("zero_no_forward", 5'd0, 32'h0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;

        // Asynchronous reset clears contents before the next edge.
        do_write(5'd31, 32'hA5A5A5A5);
        read_check("r31_written", 5'd31, 32'hA5A5A5A5, 5'd3, 32'h00000042);
        #2;
        reset = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
        read_check("reset_async", 5'd31, 32'h0, 5'd3, 32'h0);

        // Reset beats a write on the same edge and suppresses forwarding.
        @(negedge clk);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd10;
        bus.WriteData     = 32'hCAFEF00D;
        read_check("reset_no_forward", 5'd10, 32'h0, 5'd10, 32'h0);
        @(posedge clk);
        #1;
        read_check("reset_wins", 5'd10, 32'h0, 5'd31, 32'h0);

        // First edge after reset release accepts a write.
        @(negedge clk);
        reset             = 1'b0;
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = 5'd12;
        bus.WriteData     = 32'h00000077;
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        model[12] = 32'h00000077;
        read_check("first_write", 5'd12, 32'h00000077, 5'd10, 32'h0);

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
